// File: rtl/prm_edge_chk_sched.sv
// Obstacle-check scheduler: streams obstacle codes to a banked combinational
// checker array and ORs the returned edge masks into a per-edge blocked bitmap.
module prm_edge_chk_sched #(
    parameter int CODE_W     = 15,
    parameter int BANK_W     = 32,
    parameter int NUM_BANK   = 16,
    parameter int BANK_IDX_W = 4,
    parameter int CNT_W      = 16
) (
    input  logic                  CLK,
    input  logic                  RST_N,
    input  logic                  start,
    input  logic                  abort,
    input  logic                  obs_valid,
    input  logic [CODE_W-1:0]     obs_code,
    input  logic                  obs_last,
    output logic                  obs_ready,
    output logic [CODE_W-1:0]     chk_code,
    output logic [BANK_IDX_W-1:0] chk_bank,
    input  logic [BANK_W-1:0]     chk_mask,
    input  logic                  rd_en,
    input  logic [BANK_IDX_W-1:0] rd_bank,
    output logic [BANK_W-1:0]     rd_data,
    output logic                  busy,
    output logic                  done,
    output logic                  mask_valid,
    output logic [CNT_W-1:0]      obs_cnt
);

    typedef enum logic [1:0] {IDLE, FETCH, SCAN, FIN} state_t;

    localparam logic [BANK_IDX_W-1:0] LAST_BANK = BANK_IDX_W'(NUM_BANK - 1);

    state_t                  state_reg, state_next;
    logic [CODE_W-1:0]       chk_code_reg;
    logic [BANK_IDX_W-1:0]   chk_bank_reg;
    logic                    last_reg;
    logic [CNT_W-1:0]        obs_cnt_reg;
    logic                    mask_valid_reg;
    logic [BANK_W-1:0]       rd_data_reg;
    logic [BANK_W-1:0]       word_reg [NUM_BANK];
    logic [NUM_BANK-1:0]     bank_hit;
    logic [BANK_W-1:0]       rd_word;

    logic accept, wr_en, scan_last, clear_en;

    assign accept    = (state_reg == FETCH) && obs_valid && !abort;
    assign wr_en     = (state_reg == SCAN) && !abort;
    assign scan_last = wr_en && (chk_bank_reg == LAST_BANK);
    assign clear_en  = (state_reg == IDLE) && start && !abort;

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) state_reg <= IDLE;
        else        state_reg <= state_next;
    end

    always_comb begin
        state_next = state_reg;
        obs_ready  = 1'b0;
        busy       = 1'b1;
        done       = 1'b0;
        case (state_reg)
            IDLE: begin
                busy = 1'b0;
                if (start) state_next = FETCH;
            end
            FETCH: begin
                obs_ready = 1'b1;
                if (obs_valid) state_next = SCAN;
            end
            SCAN: begin
                if (chk_bank_reg == LAST_BANK) state_next = last_reg ? FIN : FETCH;
            end
            FIN: begin
                done       = 1'b1;
                state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
        if (abort) state_next = IDLE;
    end

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            chk_code_reg   <= '0;
            chk_bank_reg   <= '0;
            last_reg       <= 1'b0;
            obs_cnt_reg    <= '0;
            mask_valid_reg <= 1'b0;
        end else begin
            if (accept) begin
                chk_code_reg <= obs_code;
                last_reg     <= obs_last;
                chk_bank_reg <= '0;
                if (obs_cnt_reg != '1) obs_cnt_reg <= obs_cnt_reg + 1'b1;
            end else if (wr_en && !scan_last) begin
                chk_bank_reg <= chk_bank_reg + 1'b1;
            end
            if (clear_en) obs_cnt_reg <= '0;

            if (abort || clear_en)          mask_valid_reg <= 1'b0;
            else if (scan_last && last_reg) mask_valid_reg <= 1'b1;
        end
    end

    // One-hot bank decode keeps every bitmap word on its own simple enable.
    generate
        for (genvar gi = 0; gi < NUM_BANK; gi++) begin : g_hit
            assign bank_hit[gi] = wr_en && (chk_bank_reg == BANK_IDX_W'(gi));
        end
    endgenerate

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            for (int i = 0; i < NUM_BANK; i++) word_reg[i] <= '0;
        end else begin
            for (int i = 0; i < NUM_BANK; i++) begin
                if (clear_en)         word_reg[i] <= '0;
                else if (bank_hit[i]) word_reg[i] <= word_reg[i] | chk_mask;
            end
        end
    end

    // Out-of-range banks fall through to zero.
    always_comb begin
        rd_word = '0;
        for (int i = 0; i < NUM_BANK; i++) begin
            if (rd_bank == BANK_IDX_W'(i)) rd_word = word_reg[i];
        end
    end

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N)     rd_data_reg <= '0;
        else if (rd_en) rd_data_reg <= rd_word;
    end

    assign chk_code   = chk_code_reg;
    assign chk_bank   = chk_bank_reg;
    assign rd_data    = rd_data_reg;
    assign mask_valid = mask_valid_reg;
    assign obs_cnt    = obs_cnt_reg;

endmodule

// File: tb/tb_prm_edge_chk_sched.sv
// Bench for prm_edge_chk_sched: behavioural checker array, bitmap model and a
// read-data scoreboard; all driving and sampling happens on the falling edge.
module tb_prm_edge_chk_sched;

    localparam int CODE_W = 15;
    localparam int BANK_W = 32;
    localparam int NB     = 16;
    localparam int BIW    = 5;
    localparam int CNT_W  = 16;

    logic              CLK = 1'b0;
    logic              RST_N = 1'b0;
    logic              start = 1'b0, abort = 1'b0, obs_valid = 1'b0, obs_last = 1'b0;
    logic [CODE_W-1:0] obs_code = '0;
    logic              obs_ready;
    logic [CODE_W-1:0] chk_code;
    logic [BIW-1:0]    chk_bank;
    logic [BANK_W-1:0] chk_mask;
    logic              rd_en = 1'b0;
    logic [BIW-1:0]    rd_bank = '0;
    logic [BANK_W-1:0] rd_data;
    logic              busy, done, mask_valid;
    logic [CNT_W-1:0]  obs_cnt;

    int errors = 0;
    int checks = 0;
    int mode   = 0;
    logic [BANK_W-1:0] model [NB];
    logic [BANK_W-1:0] exp_q [$];

    prm_edge_chk_sched #(.CODE_W(CODE_W), .BANK_W(BANK_W), .NUM_BANK(NB),
                         .BANK_IDX_W(BIW), .CNT_W(CNT_W)) dut (
        .CLK(CLK), .RST_N(RST_N), .start(start), .abort(abort),
        .obs_valid(obs_valid), .obs_code(obs_code), .obs_last(obs_last),
        .obs_ready(obs_ready), .chk_code(chk_code), .chk_bank(chk_bank),
        .chk_mask(chk_mask), .rd_en(rd_en), .rd_bank(rd_bank), .rd_data(rd_data),
        .busy(busy), .done(done), .mask_valid(mask_valid), .obs_cnt(obs_cnt)
    );

    always #5 CLK = ~CLK;

    function automatic logic [BANK_W-1:0] chk_fn(int m, logic [CODE_W-1:0] code, int bank);
        logic [BANK_W-1:0] r;
        r = '0;
        if (m == 0) r = 32'h1 << bank;
        else if (m == 1 && bank == 2) begin
            if (code == 1 || code == 3) r = 32'h0000_00F0;
            else if (code == 2)         r = 32'h0F00_0000;
        end else if (m == 2) r = 32'hFFFF_FFFF;
        return r;
    endfunction

    always_comb chk_mask = chk_fn(mode, chk_code, int'(chk_bank));

    task automatic do_reset();
        RST_N = 1'b0;
        repeat (3) @(negedge CLK);
        RST_N = 1'b1;
        @(negedge CLK);
        for (int b = 0; b < NB; b++) model[b] = '0;
    endtask

    task automatic start_job();
        start = 1'b1;
        @(negedge CLK);
        start = 1'b0;
        for (int b = 0; b < NB; b++) model[b] = '0;
    endtask

    // Returns at the falling edge right after the handshake edge.
    task automatic send_obs(input logic [CODE_W-1:0] code, input logic last);
        int n;
        obs_valid = 1'b1; obs_code = code; obs_last = last;
        n = 0;
        while (!obs_ready && n < 100) begin @(negedge CLK); n++; end
        checks++;
        if (!obs_ready) begin errors++; $display("FAIL send_obs_timeout code=%h", code); end
        @(posedge CLK);
        for (int b = 0; b < NB; b++) model[b] |= chk_fn(mode, code, b);
        @(negedge CLK);
        obs_valid = 1'b0; obs_last = 1'b0;
        $display("obs code=%h last=%0b accepted", code, last);
    endtask

    task automatic wait_done(output int n);
        n = 1;
        while (!done && n < 200) begin @(negedge CLK); n++; end
        checks++;
        if (!done) begin errors++; $display("FAIL done_timeout cycles=%0d", n); end
    endtask

    task automatic wait_bank(input int b);
        int n;
        n = 0;
        while (int'(chk_bank) != b && n < 100) begin @(negedge CLK); n++; end
        checks++;
        if (int'(chk_bank) != b) begin errors++; $display("FAIL wait_bank got=%0d want=%0d", chk_bank, b); end
    endtask

    task automatic read_check(input int b, input string tag);
        logic [BANK_W-1:0] e;
        exp_q.push_back((b < NB) ? model[b] : '0);
        rd_en = 1'b1; rd_bank = BIW'(b);
        @(negedge CLK);
        rd_en = 1'b0;
        e = exp_q.pop_front();
        checks++;
        if (rd_data !== e) begin
            errors++;
            $display("FAIL %s bank=%0d got=%h exp=%h", tag, b, rd_data, e);
        end else $display("read %s bank=%0d data=%h", tag, b, rd_data);
    endtask

    task automatic test_reset();
        do_reset();
        checks++;
        if ({busy, mask_valid, obs_ready, done} !== 4'b0 || obs_cnt !== '0 ||
            chk_code !== '0 || chk_bank !== '0) begin
            errors++;
            $display("FAIL reset_outputs busy=%b mv=%b rdy=%b done=%b cnt=%0d code=%h bank=%0d exp all 0",
                     busy, mask_valid, obs_ready, done, obs_cnt, chk_code, chk_bank);
        end
        read_check(5, "reset");
    endtask

    task automatic test_single();
        int n;
        mode = 0;
        start_job();
        send_obs(15'h1234, 1'b1);
        wait_done(n);
        checks++;
        if (n != NB + 1) begin errors++; $display("FAIL single_latency got=%0d exp=%0d", n, NB + 1); end
        checks++;
        if (mask_valid !== 1'b1 || obs_cnt !== 16'd1) begin
            errors++;
            $display("FAIL single_status mv=%b cnt=%0d exp mv=1 cnt=1", mask_valid, obs_cnt);
        end
        @(negedge CLK);
        checks++;
        if (done !== 1'b0 || busy !== 1'b0 || mask_valid !== 1'b1) begin
            errors++;
            $display("FAIL single_after done=%b busy=%b mv=%b exp 0 0 1", done, busy, mask_valid);
        end
        for (int b = 0; b < NB; b++) read_check(b, "single");
        read_check(NB, "out_of_range");
    endtask

    task automatic test_or_accum();
        int n;
        mode = 1;
        start_job();
        send_obs(15'd1, 1'b0);
        send_obs(15'd2, 1'b0);
        send_obs(15'd3, 1'b1);
        wait_done(n);
        checks++;
        if (obs_cnt !== 16'd3 || model[2] !== 32'h0F00_00F0) begin
            errors++;
            $display("FAIL or_count cnt=%0d exp=3 model2=%h", obs_cnt, model[2]);
        end
        for (int b = 0; b < NB; b++) read_check(b, "or_accum");
    endtask

    task automatic test_stall();
        int lows;
        mode = 0;
        start_job();
        for (int i = 0; i < 10; i++) begin
            checks++;
            if (busy !== 1'b1 || obs_ready !== 1'b1) begin
                errors++;
                $display("FAIL stall_fetch cyc=%0d busy=%b rdy=%b exp 1 1", i, busy, obs_ready);
            end
            @(negedge CLK);
        end
        read_check(2, "stall");
        send_obs(15'h0055, 1'b1);
        lows = 0;
        for (int i = 0; i < NB; i++) begin
            if (obs_ready === 1'b0 && busy === 1'b1) lows++;
            @(negedge CLK);
        end
        checks++;
        if (lows != NB || done !== 1'b1) begin
            errors++;
            $display("FAIL scan_ready_low lows=%0d exp=%0d done=%b exp=1", lows, NB, done);
        end
        @(negedge CLK);
    endtask

    task automatic test_abort();
        logic saw_done;
        mode = 0;
        start_job();
        send_obs(15'h0777, 1'b0);
        saw_done = 1'b0;
        while (int'(chk_bank) != 7 && busy) begin
            if (done) saw_done = 1'b1;
            @(negedge CLK);
        end
        checks++;
        if (int'(chk_bank) != 7) begin errors++; $display("FAIL abort_reach bank=%0d exp=7", chk_bank); end
        abort = 1'b1;
        @(negedge CLK);
        abort = 1'b0;
        if (done) saw_done = 1'b1;
        checks++;
        if (busy !== 1'b0 || mask_valid !== 1'b0 || saw_done || obs_cnt !== 16'd1) begin
            errors++;
            $display("FAIL abort_state busy=%b mv=%b saw_done=%b cnt=%0d exp 0 0 0 1",
                     busy, mask_valid, saw_done, obs_cnt);
        end
        repeat (5) begin
            @(negedge CLK);
            checks++;
            if (done !== 1'b0 || busy !== 1'b0) begin
                errors++;
                $display("FAIL abort_idle done=%b busy=%b exp 0 0", done, busy);
            end
        end
        for (int b = 0; b < 7; b++) read_check(b, "abort_keep");
        start_job();
        for (int b = 0; b < NB; b++) read_check(b, "restart_clear");
        abort = 1'b1;
        @(negedge CLK);
        abort = 1'b0;
    endtask

    task automatic test_collision();
        int n;
        mode = 2;
        start_job();
        send_obs(15'h7FFF, 1'b1);
        wait_bank(3);
        rd_en = 1'b1; rd_bank = BIW'(3);
        @(negedge CLK);
        checks++;
        if (rd_data !== 32'h0) begin errors++; $display("FAIL collide_pre got=%h exp=00000000", rd_data); end
        @(negedge CLK);
        rd_en = 1'b0;
        checks++;
        if (rd_data !== 32'hFFFF_FFFF) begin errors++; $display("FAIL collide_post got=%h exp=ffffffff", rd_data); end
        wait_done(n);
        read_check(NB, "collide_oor");
        read_check(9, "collide_full");
    endtask

    initial begin
        test_reset();
        test_single();
        test_or_accum();
        test_stall();
        test_abort();
        test_collision();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL global_timeout");
        $fatal(1, "timeout");
    end

endmodule

// File: doc/prm_edge_chk_sched.md
Name: prm_edge_chk_sched

Overview:
- Sequences the bank of prm_oblgc_chk* obstacle-check instances across a stream of 15-bit obstacle codes.
- The external checker array is combinational and grouped into NUM_BANK banks of BANK_W edges.
- This block streams in obstacle codes, broadcasts each code bank by bank, and ORs the returned edge_mask bits into a per-edge blocked bitmap.
- The bitmap is exposed through a registered read port for the roadmap planner.

Parameters:
- CODE_W, 15, obstacle code width (checker inputs A..O, A = bit 0).
- BANK_W, 32, edge_mask bits returned per bank per cycle.
- NUM_BANK, 16, number of checker banks; total edges = BANK_W*NUM_BANK.
- BANK_IDX_W, 4, width of bank index, >= clog2(NUM_BANK).
- CNT_W, 16, obstacle counter width.

Ports:
- CLK  in  1  clock, all state on rising edge.
- RST_N  in  1  asynchronous active-low reset.
- start  in  1  pulse: clear bitmap, begin a new scan job.
- abort  in  1  pulse: terminate job, return to IDLE.
- obs_valid  in  1  obstacle code valid.
- obs_code  in  CODE_W  obstacle code.
- obs_last  in  1  marks final obstacle of the job.
- obs_ready  out  1  obstacle accept.
- chk_code  out  CODE_W  registered code driven to checker array.
- chk_bank  out  BANK_IDX_W  registered bank select to checker array.
- chk_mask  in  BANK_W  combinational edge_mask vector for the current chk_code/chk_bank.
- rd_en  in  1  bitmap read request.
- rd_bank  in  BANK_IDX_W  bank word to read.
- rd_data  out  BANK_W  registered read data, 1 = edge blocked.
- busy  out  1  high in any state except IDLE.
- done  out  1  one-cycle pulse on job completion.
- mask_valid  out  1  bitmap complete and coherent.
- obs_cnt  out  CNT_W  obstacles processed in the current or last job.

Behaviour:
- Reset values: all outputs 0 (obs_ready, chk_code, chk_bank, rd_data, busy, done, mask_valid, obs_cnt). Bitmap is cleared to 0 and the FSM enters IDLE.
- FSM states: IDLE, FETCH, SCAN, FIN.
  - IDLE: start=1 clears all NUM_BANK bitmap words in one cycle, clears obs_cnt and mask_valid, then moves to FETCH. start in any other state is ignored.
  - FETCH: obs_ready=1. On obs_valid&obs_ready:
    - latch code into chk_code and obs_last into last_r;
    - set chk_bank=0, obs_cnt+=1 (saturating at all-ones);
    - move to SCAN.
  - SCAN: each cycle, word[chk_bank] |= chk_mask, then chk_bank+=1.
    - After the word for bank NUM_BANK-1 is written: if last_r, go to FIN; else go to FETCH.
    - obs_ready=0 throughout SCAN.
  - FIN: done=1 and mask_valid=1 for this single cycle; next state IDLE. mask_valid stays 1 until the next start.
- Throughput: NUM_BANK+1 cycles per obstacle (1 FETCH + NUM_BANK SCAN), given obs_valid is held high.
- chk_code and chk_bank hold their last values when not scanning; the checker output is ignored outside SCAN.
- Checker sampling: chk_mask is sampled on the same edge that advances chk_bank, so the checker array must settle within one cycle.
- Accumulation is OR only; a bit never clears except on start or reset.
- Read port:
  - rd_en=1 gives rd_data = word[rd_bank] on the next cycle; with rd_en=0, rd_data holds.
  - Reads are legal in every state.
  - A read of the bank being ORed in the same cycle returns the pre-update value.
  - rd_bank >= NUM_BANK returns 0.
- abort has priority over start and over all transitions. From any state it moves to IDLE next cycle with:
  - done=0, mask_valid=0;
  - bitmap and obs_cnt retained (partial result, for debug).
- Job with a single obstacle: obs_last on the first code gives FETCH, SCAN x NUM_BANK, FIN.
- obs_valid low in FETCH: the FSM waits indefinitely, busy stays 1.
- Reset asserted mid-job: immediate return to the reset state; partial results are lost.

Test Plan:
- Reset then idle: RST_N low then high; rd_en, rd_bank=5 -> rd_data=0, busy=0, mask_valid=0, obs_ready=0.
- Single obstacle: start, obs_code=15'h1234 with obs_last; checker model returns chk_mask=32'h1<<bank -> done exactly NUM_BANK+1 cycles after the handshake, mask_valid=1, word[b]=1<<b for every b, obs_cnt=1.
- OR accumulation: 3 obstacles; masks 32'h0000_00F0, 32'h0F00_0000, 32'h0000_00F0 on bank 2 only -> word[2]=32'h0F00_00F0, other words 0, obs_cnt=3.
- Backpressure and stall: obs_valid low for 10 cycles in FETCH -> busy=1, obs_ready=1, no bitmap change. obs_ready=0 for all NUM_BANK SCAN cycles.
- Abort mid-SCAN at bank 7 -> IDLE next cycle, done never pulses, mask_valid=0, banks 0..6 retain ORed data, start re-clears all words to 0.
- Read/update collision: rd_bank=chk_bank while that word is updated from 0 to 32'hFFFF_FFFF -> rd_data=0; the same read one cycle later -> 32'hFFFF_FFFF. rd_bank=NUM_BANK -> 0.
